// File: rtl/oscillator_sampler.sv
// oscillator_sampler: per-voice phase counter shaped into saw/square/triangle,
// presented once every SAMPLE_DIV clocks with a one-cycle sample_now strobe.
module oscillator_sampler #(
    parameter int SAMPLE_DIV = 256,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic [CNT_W-1:0] divisor,
    input  logic [1:0]       wave_sel,
    output logic [CNT_W-1:0] oscillator_out,
    output logic             sample_now
);
    localparam int SW = $clog2(SAMPLE_DIV);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [SW-1:0]    samp_cnt;
    logic [CNT_W-1:0] phase, phase_nxt, act_div, act_div_nxt, half, shaped;
    logic [CNT_W:0]   tri_raw;
    logic             wrap, lower, strobe, silent, div_ok;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            phase   <= '0;
            act_div <= '0;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            act_div <= act_div_nxt;
        end
    end

    // act_div only follows divisor at a wrap or while idle, so phase never exceeds act_div-1
    always_comb begin
        wrap        = phase == act_div - 1'b1;
        div_ok      = divisor >= CNT_W'(2);
        state_nxt   = IDLE;
        phase_nxt   = '0;
        act_div_nxt = divisor;
        if (state == RUN) begin
            state_nxt = !en ? IDLE : wrap ? (div_ok ? RUN : IDLE) : RUN;
            if (en && !wrap) begin
                phase_nxt   = phase + 1'b1;
                act_div_nxt = act_div;
            end
        end else begin
            state_nxt = en && div_ok ? RUN : IDLE;
        end
    end

    // Triangle peaks at phase==half; odd divisors can overshoot by one, hence the saturation
    always_comb begin
        half    = act_div >> 1;
        lower   = phase < half;
        tri_raw = lower ? {phase, 1'b0} : {act_div - phase, 1'b0};
        silent  = state != RUN || !en || wave_sel == 2'b11;
        shaped  = silent ? '0 :
                  wave_sel == 2'b00 ? phase :
                  wave_sel == 2'b01 ? (lower ? '0 : act_div) :
                  tri_raw > {1'b0, act_div} ? act_div : tri_raw[CNT_W-1:0];
    end

    assign strobe = samp_cnt == SW'(SAMPLE_DIV - 1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            samp_cnt       <= '0;
            sample_now     <= 1'b0;
            oscillator_out <= '0;
        end else begin
            samp_cnt   <= strobe ? '0 : samp_cnt + 1'b1;
            sample_now <= strobe;
            if (strobe) oscillator_out <= shaped;
        end
    end
endmodule

// File: tb/tb_oscillator_sampler.sv
// tb_oscillator_sampler: two samplers (SAMPLE_DIV 16 and 17) checked against a
// behavioural model that queues the expected value of every strobe.
module tb_oscillator_sampler;
    logic        tb_clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en = 1'b0;
    logic [15:0] divisor = '0;
    logic [1:0]  wave_sel = '0;
    logic [15:0] out [2];
    logic        sn [2];
    int          checks = 0;
    int          errors = 0;

    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int f_shape(input logic [1:0] w, input logic e, input int p, input int d);
        int h, t;
        h = d / 2;
        if (!e || d < 2 || w == 2'b11) return 0;
        if (w == 2'b00) return p;
        if (w == 2'b01) return p < h ? 0 : d;
        t = p < h ? 2 * p : 2 * (d - p);
        return t > d ? d : t;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : ch
        localparam int SD = 16 + g;
        int m_phase, m_div, m_cnt;
        bit m_en_d, m_strobe;
        int q[$];

        oscillator_sampler #(.SAMPLE_DIV(SD), .CNT_W(16)) u_dut (
            .clk(tb_clk),
            .nrst(nrst),
            .en(en),
            .divisor(divisor),
            .wave_sel(wave_sel),
            .oscillator_out(out[g]),
            .sample_now(sn[g])
        );

        always @(posedge tb_clk or negedge nrst) begin : model
            bit act, wr;
            if (!nrst) begin
                m_phase  = 0;
                m_div    = 0;
                m_cnt    = 0;
                m_en_d   = 0;
                m_strobe = 0;
                q.delete();
            end else begin
                m_strobe = m_cnt == SD - 1;
                if (m_strobe) q.push_back(f_shape(wave_sel, en, m_phase, m_div));
                m_cnt   = m_strobe ? 0 : m_cnt + 1;
                act     = en && m_en_d && m_div >= 2;
                wr      = act && m_phase == m_div - 1;
                m_phase = act && !wr ? m_phase + 1 : 0;
                if (wr || !act) m_div = int'(divisor);
                m_en_d  = en;
            end
        end

        always @(negedge tb_clk) begin
            chk($sformatf("strobe%0d", g), int'(sn[g]), int'(m_strobe));
            if (sn[g]) begin
                if (q.size() == 0) chk($sformatf("queue%0d", g), 0, 1);
                else chk($sformatf("out%0d", g), int'(out[g]), q.pop_front());
                if (divisor == 16'd22727)
                    chk("quotient_range", int'((int'(out[g]) * 255 + 11363) / 22727 <= 255), 1);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic latency_check();
        int n = 0;
        do begin
            @(negedge tb_clk);
            n++;
        end while (!sn[0] && n < 100);
        chk("first_strobe_latency", n, 16);
    endtask

    initial begin
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        chk("reset_out0", int'(out[0]), 0);
        chk("reset_sn0", int'(sn[0]), 0);
        chk("reset_out1", int'(out[1]), 0);
        nrst = 1'b1;
        latency_check();
        en = 1'b1; divisor = 16'd100; wave_sel = 2'b00;
        run(16 * 12);
        divisor = 16'd8; wave_sel = 2'b01;
        run(160);
        wave_sel = 2'b10;
        run(300);
        divisor = 16'd100; wave_sel = 2'b00;
        run(200);
        for (int i = 0; i < 200; i++) begin
            @(negedge tb_clk);
            if (ch[0].m_phase == 30) break;
        end
        chk("retune_phase", ch[0].m_phase, 30);
        divisor = 16'd50;
        run(300);
        en = 1'b0;
        run(50);
        en = 1'b1; divisor = 16'd100; wave_sel = 2'b11;
        run(50);
        wave_sel = 2'b00; divisor = 16'd1;
        run(100);
        divisor = 16'd100;
        run(100);
        divisor = 16'd22727; wave_sel = 2'b10;
        run(3000);
        divisor = 16'd100; wave_sel = 2'b00;
        begin
            int n = 0;
            do begin
                @(negedge tb_clk);
                n++;
            end while (!sn[0] && n < 100);
            chk("strobe_before_reset", int'(sn[0]), 1);
        end
        #2 nrst = 1'b0;
        #1;
        chk("async_out0", int'(out[0]), 0);
        chk("async_sn0", int'(sn[0]), 0);
        chk("async_out1", int'(out[1]), 0);
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        nrst = 1'b1;
        latency_check();
        run(200);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
